// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter.
// Holds the FSM state encoding and the default debug burst limit.
package dmem_arb_pkg;

  localparam int DBG_BURST_MAX_DEF = 4;
  localparam int BURST_W = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GNT_CPU  = 3'd1,
    GNT_DBG  = 3'd2,
    RESP_CPU = 3'd3,
    RESP_DBG = 3'd4
  } state_t;

  // Debug normally wins a tie; cpu_first hands the
  // slot to the CPU once the debug burst is used up.
  function automatic state_t arb_pick(
    input logic cpu,
    input logic dbg,
    input logic cpu_first
  );
    state_t s;
    s = IDLE;
    if (dbg && !(cpu && cpu_first)) begin
      s = GNT_DBG;
    end else if (cpu) begin
      s = GNT_CPU;
    end
    return s;
  endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Two-requester (CPU, debug) arbiter for a single-port data memory.
// Ports: SYS_clk/SYS_reset; cpu_* and dbg_* request/response; mem_* drive.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 32,
  parameter int DBG_BURST_MAX = DBG_BURST_MAX_DEF
) (
  input  logic              SYS_clk,
  input  logic              SYS_reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_valid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_fault
);

  localparam logic [BURST_W-1:0] BMAX =
    BURST_W'(DBG_BURST_MAX);

  state_t             state;
  state_t             state_nx;
  logic [BURST_W-1:0] burst_cnt;
  logic [BURST_W-1:0] burst_nx;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic               rsp_we;
  logic               issue_we;
  logic               in_gnt;
  logic               cpu_turn;
  logic               in_rcpu;
  logic               in_rdbg;

  assign cpu_turn = (burst_cnt == BMAX);
  assign in_gnt   = (state == GNT_CPU) ||
                    (state == GNT_DBG);
  assign in_rcpu  = (state == RESP_CPU);
  assign in_rdbg  = (state == RESP_DBG);

  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      state     <= IDLE;
      burst_cnt <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rsp_we    <= 1'b0;
    end else begin
      state     <= state_nx;
      burst_cnt <= burst_nx;
      if (in_gnt) begin
        addr_q  <= mem_addr;
        wdata_q <= mem_wdata;
        rsp_we  <= issue_we;
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, RESP_CPU, RESP_DBG:
        state_nx = arb_pick(cpu_req, dbg_req,
                            cpu_turn);
      GNT_CPU: state_nx = RESP_CPU;
      GNT_DBG: state_nx = RESP_DBG;
      default: state_nx = IDLE;
    endcase
  end

  // Counts debug grants taken while the CPU waits.
  always_comb begin
    burst_nx = burst_cnt;
    if (!cpu_req) begin
      burst_nx = '0;
    end else if (state_nx == GNT_CPU) begin
      burst_nx = '0;
    end else if (state_nx == GNT_DBG &&
                 burst_cnt != BMAX) begin
      burst_nx = burst_cnt + 1'b1;
    end
  end

  // Outside a grant the port keeps the last
  // granted address/data; only the strobe drops.
  always_comb begin
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    mem_we    = 1'b0;
    issue_we  = 1'b0;
    case (state)
      GNT_CPU: begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        issue_we  = cpu_we;
        mem_we    = cpu_we && !mem_fault;
      end
      GNT_DBG: begin
        mem_addr  = dbg_addr;
        mem_wdata = dbg_wdata;
        issue_we  = dbg_we;
        mem_we    = dbg_we;
      end
      default: begin
        mem_we = 1'b0;
      end
    endcase
  end

  // Reset in a response cycle abandons the access,
  // so the completion strobes are masked by it.
  assign cpu_valid = in_rcpu && !SYS_reset;
  assign dbg_ack   = in_rdbg && !SYS_reset;

  assign cpu_rdata = (in_rcpu && !rsp_we) ?
                     mem_rdata : '0;
  assign dbg_rdata = (in_rdbg && !rsp_we) ?
                     mem_rdata : '0;

  assign cpu_stall = cpu_req && !cpu_valid;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed cases, then random
// traffic, against a transaction-level reference model.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int BM = 4;

  logic          SYS_clk = 1'b0;
  logic          SYS_reset = 1'b1;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_stall;
  logic          cpu_valid;
  logic [DW-1:0] cpu_rdata;
  logic          dbg_req = 1'b0;
  logic          dbg_we = 1'b0;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_wdata = '0;
  logic          dbg_ack;
  logic [DW-1:0] dbg_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;
  logic          mem_fault = 1'b0;
  logic          mem_clr = 1'b1;

  int n_asrt = 0;
  int n_fail = 0;

  dmem_arbiter #(
    .DATA_W(DW), .ADDR_W(AW), .DBG_BURST_MAX(BM)
  ) dut (
    .SYS_clk(SYS_clk), .SYS_reset(SYS_reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_valid(cpu_valid),
    .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata),
    .mem_fault(mem_fault)
  );

  always #5 SYS_clk = ~SYS_clk;

  function automatic logic [31:0] init_val(
    input logic [7:0] a);
    case (a)
      8'h10:   return 32'hDEADBEEF;
      8'h20:   return 32'h00001234;
      default: return {24'h5A0000, a};
    endcase
  endfunction

  // Data memory: one-cycle registered read.
  logic [31:0] mem [256];
  logic        wr  [256];
  always @(posedge SYS_clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) wr[i] <= 1'b0;
    end else if (mem_we) begin
      mem[mem_addr[7:0]] <= mem_wdata;
      wr[mem_addr[7:0]]  <= 1'b1;
    end
    mem_rdata <= wr[mem_addr[7:0]] ?
                 mem[mem_addr[7:0]] :
                 init_val(mem_addr[7:0]);
  end

  // Reference model. An access occupies an issue
  // slot (g) then a completion slot (r); 0 none,
  // 1 cpu, 2 dbg. New winners are chosen only when
  // no issue slot is occupied.
  logic [31:0] ref_mem [256];
  logic        ref_wr  [256];
  int          g = 0;
  int          r = 0;
  logic        r_we = 1'b0;
  logic [31:0] r_data = '0;
  int          burst = 0;
  logic [31:0] l_addr = '0;
  logic [31:0] l_wdata = '0;

  function automatic logic [31:0] ref_rd(
    input logic [7:0] a);
    return ref_wr[a] ? ref_mem[a] : init_val(a);
  endfunction

  task automatic model_edge();
    logic [31:0] a, d, rd;
    logic        we;
    int          ng;
    a = '0; d = '0; we = 1'b0; rd = '0; ng = 0;
    if (g != 0) begin
      a  = (g == 1) ? cpu_addr  : dbg_addr;
      d  = (g == 1) ? cpu_wdata : dbg_wdata;
      we = (g == 1) ? cpu_we    : dbg_we;
      rd = ref_rd(a[7:0]);
      if (we && !(g == 1 && mem_fault)) begin
        ref_mem[a[7:0]] = d;
        ref_wr[a[7:0]]  = 1'b1;
      end
    end
    if (SYS_reset) begin
      g = 0; r = 0; burst = 0; r_we = 1'b0;
      l_addr = '0; l_wdata = '0;
    end else begin
      r = g;
      if (g != 0) begin
        r_we = we; r_data = rd;
        l_addr = a; l_wdata = d;
      end
      if (g == 0) begin
        if (dbg_req && cpu_req)
          ng = (burst == BM) ? 1 : 2;
        else if (dbg_req) ng = 2;
        else if (cpu_req) ng = 1;
      end
      if (!cpu_req || ng == 1) burst = 0;
      else if (ng == 2 && burst < BM) burst++;
      g = ng;
    end
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic        cv, da, ew;
    logic [31:0] ea, ed, crd, drd;
    cv = (r == 1) && !SYS_reset;
    da = (r == 2) && !SYS_reset;
    ew = (g == 1) ? (cpu_we && !mem_fault) :
         (g == 2) ? dbg_we : 1'b0;
    ea = (g == 1) ? cpu_addr :
         (g == 2) ? dbg_addr : l_addr;
    ed = (g == 1) ? cpu_wdata :
         (g == 2) ? dbg_wdata : l_wdata;
    crd = (r == 1 && !r_we) ? r_data : '0;
    drd = (r == 2 && !r_we) ? r_data : '0;
    chk("mem_we", 32'(mem_we), 32'(ew));
    chk("mem_addr", mem_addr, ea);
    chk("mem_wdata", mem_wdata, ed);
    chk("cpu_valid", 32'(cpu_valid), 32'(cv));
    chk("cpu_rdata", cpu_rdata, crd);
    chk("cpu_stall", 32'(cpu_stall),
        32'(cpu_req && !cv));
    chk("dbg_ack", 32'(dbg_ack), 32'(da));
    chk("dbg_rdata", dbg_rdata, drd);
  endtask

  task automatic step();
    @(posedge SYS_clk);
    model_edge();
    @(negedge SYS_clk);
    check_all();
  endtask

  task automatic idle_in();
    cpu_req = 1'b0; cpu_we = 1'b0;
    dbg_req = 1'b0; dbg_we = 1'b0;
    mem_fault = 1'b0;
  endtask

  initial begin
    int acks;
    int k;
    for (int i = 0; i < 256; i++) begin
      ref_wr[i] = 1'b0; ref_mem[i] = '0;
    end
    // Reset, with a CPU request held high.
    cpu_req = 1'b1;
    step();
    chk("rst_stall", 32'(cpu_stall), 32'd1);
    mem_clr = 1'b0;
    cpu_req = 1'b0;
    step();
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    SYS_reset = 1'b0;
    step();

    // CPU-only read of 0x10.
    cpu_req = 1'b1; cpu_addr = 32'h10;
    step();
    chk("rd_addr_c1", mem_addr, 32'h10);
    step();
    chk("rd_valid_c2", 32'(cpu_valid), 32'd1);
    chk("rd_data_c2", cpu_rdata, 32'hDEADBEEF);
    chk("rd_stall_c2", 32'(cpu_stall), 32'd0);
    idle_in();
    step();

    // Simultaneous requests: debug first.
    cpu_req = 1'b1; cpu_addr = 32'h10;
    dbg_req = 1'b1; dbg_addr = 32'h20;
    step();
    chk("sim_dbg_c1", mem_addr, 32'h20);
    step();
    chk("sim_ack_c2", 32'(dbg_ack), 32'd1);
    chk("sim_drd_c2", dbg_rdata, 32'h1234);
    dbg_req = 1'b0;
    step();
    chk("sim_cpu_c3", mem_addr, 32'h10);
    step();
    chk("sim_valid_c4", 32'(cpu_valid), 32'd1);
    idle_in();
    step();

    // Starvation bound with both held high.
    cpu_req = 1'b1; dbg_req = 1'b1;
    acks = 0;
    for (k = 0; k < 40; k++) begin
      step();
      if (cpu_valid) break;
      if (dbg_ack) acks++;
    end
    chk("burst_acks", 32'(acks), 32'd4);
    chk("burst_bound", 32'(k < 40), 32'd1);
    chk("burst_clr", 32'(dut.burst_cnt), 32'd0);
    idle_in();
    step();
    step();

    // Faulted CPU write is suppressed.
    cpu_req = 1'b1; cpu_we = 1'b1;
    cpu_addr = 32'h20; cpu_wdata = 32'h55;
    mem_fault = 1'b1;
    step();
    chk("flt_we", 32'(mem_we), 32'd0);
    step();
    chk("flt_valid", 32'(cpu_valid), 32'd1);
    idle_in();
    step();
    cpu_req = 1'b1;
    step();
    step();
    chk("flt_old", cpu_rdata, 32'h1234);
    idle_in();
    step();

    // Reset during a debug grant.
    dbg_req = 1'b1; dbg_addr = 32'h10;
    step();
    chk("rm_addr", mem_addr, 32'h10);
    SYS_reset = 1'b1;
    step();
    chk("rm_ack", 32'(dbg_ack), 32'd0);
    chk("rm_state", 32'(dut.state), 32'(IDLE));
    chk("rm_addr0", mem_addr, 32'd0);
    chk("rm_we0", 32'(mem_we), 32'd0);
    chk("rm_drd0", dbg_rdata, 32'd0);
    SYS_reset = 1'b0;
    idle_in();
    step();

    // Debug write dropped in its grant, under fault.
    dbg_req = 1'b1; dbg_we = 1'b1;
    dbg_addr = 32'h30; dbg_wdata = 32'hCAFE;
    mem_fault = 1'b1;
    step();
    chk("ld_we", 32'(mem_we), 32'd1);
    dbg_req = 1'b0;
    step();
    chk("ld_ack", 32'(dbg_ack), 32'd1);
    step();
    chk("ld_ack_once", 32'(dbg_ack), 32'd0);
    chk("ld_idle", 32'(dut.state), 32'(IDLE));
    idle_in();
    cpu_req = 1'b1; cpu_addr = 32'h30;
    step();
    step();
    chk("ld_read", cpu_rdata, 32'hCAFE);
    idle_in();
    step();

    // Random traffic.
    for (int n = 0; n < 800; n++) begin
      if (!cpu_req || (r == 1 && !SYS_reset)) begin
        cpu_req   = ($urandom_range(0, 2) != 0);
        cpu_we    = $urandom_range(0, 1) == 1;
        cpu_addr  = 32'($urandom_range(0, 15));
        cpu_wdata = $urandom;
      end
      if (!dbg_req || (r == 2 && !SYS_reset)) begin
        dbg_req   = ($urandom_range(0, 2) == 0);
        dbg_we    = $urandom_range(0, 1) == 1;
        dbg_addr  = 32'($urandom_range(0, 15));
        dbg_wdata = $urandom;
      end else if ($urandom_range(0, 19) == 0) begin
        dbg_req = 1'b0;
      end
      mem_fault = ($urandom_range(0, 4) == 0);
      SYS_reset = ($urandom_range(0, 99) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
